// File: rtl/fifo_rd_pkg.sv
// fifo_rd_stream shared types.
// State encoding and default counter width.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FLUSH = 2'd3
  } rd_state_e;

  typedef logic [1:0] occ_t;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry main/skid holding buffer.
// dout is always the oldest held word.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [DSIZE-1:0] din,
  output logic [DSIZE-1:0] dout,
  output logic             rdy
);

  occ_t             occ_q, occ_d;
  logic [DSIZE-1:0] main_q, main_d;
  logic [DSIZE-1:0] skid_q, skid_d;

  assign dout = main_q;
  assign rdy  = (occ_q != 2'd2);

  // occupancy and data movement; clear drops every held word
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (clear) begin
      occ_d = 2'd0;
    end else begin
      unique case (1'b1)
        push & pop: begin
          main_d = din;
        end
        push & ~pop: begin
          if (occ_q == 2'd0) begin
            main_d = din;
            occ_d  = 2'd1;
          end else begin
            skid_d = din;
            occ_d  = 2'd2;
          end
        end
        ~push & pop: begin
          if (occ_q == 2'd2) begin
            main_d = skid_q;
            occ_d  = 2'd1;
          end else begin
            occ_d  = 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // buffer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side consumer: pops into a skid
// buffer and drives a valid/ready stream.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             flush,
  output logic             flush_busy,
  output logic [CNT_W-1:0] pop_count
);

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buf_rdy;
  logic             push;
  logic             xfer;
  logic             clear;

  assign flush_busy = (state_q == FLUSH);
  assign m_valid    = (state_q == ONE) |
                      (state_q == TWO);
  assign pop_count  = cnt_q;

  // buffer is never full while flushing
  assign rinc  = ~rempty & rrst_n &
                 (flush_busy | buf_rdy);
  assign xfer  = m_valid & m_ready;
  assign push  = rinc & ~flush_busy;
  assign clear = flush & ~flush_busy;

  rd_skid_buf #(
    .DSIZE (DSIZE)
  ) u_buf (
    .clk   (rclk),
    .rst_n (rrst_n),
    .push  (push),
    .pop   (xfer),
    .clear (clear),
    .din   (rdata),
    .dout  (m_data),
    .rdy   (buf_rdy)
  );

  // next state and delivered-word count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, xfer};
    unique case (state_q)
      EMPTY: begin
        if (flush)     state_d = FLUSH;
        else if (push) state_d = ONE;
      end
      ONE: begin
        if (flush)             state_d = FLUSH;
        else if (push & ~xfer) state_d = TWO;
        else if (~push & xfer) state_d = EMPTY;
      end
      TWO: begin
        if (flush)     state_d = FLUSH;
        else if (xfer) state_d = ONE;
      end
      FLUSH: begin
        if (~flush & rempty) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // state and counter registers
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with
// a queue-based FIFO model on the read side.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       flush;
  logic       flush_busy;
  logic [15:0] pop_count;

  logic       rinc4, m_valid4, fb4;
  logic [7:0] m_data4;
  logic [3:0] pc4;

  logic       pop_s, xfer_s;
  logic [7:0] dat_s;

  logic [7:0] fifo[$];
  logic [7:0] sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;

  always #5 clk = ~clk;

  fifo_rd_stream u_dut (
    .rclk       (clk),
    .rrst_n     (rrst_n),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .flush      (flush),
    .flush_busy (flush_busy),
    .pop_count  (pop_count)
  );

  fifo_rd_stream #(.CNT_W(4)) u_dut4 (
    .rclk       (clk),
    .rrst_n     (rrst_n),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc4),
    .m_data     (m_data4),
    .m_valid    (m_valid4),
    .m_ready    (m_ready),
    .flush      (flush),
    .flush_busy (fb4),
    .pop_count  (pc4)
  );

  always @(posedge clk) begin
    pop_s  <= rinc;
    xfer_s <= m_valid & m_ready;
    dat_s  <= m_data;
  end

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic upd();
    rempty = (fifo.size() == 0);
    rdata  = rempty ? 8'h00 : fifo[0];
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (pop_s) begin
      pops++;
      if (fifo.size() == 0)
        check("pop_when_empty", 1, 0);
      else
        void'(fifo.pop_front());
    end
    if (xfer_s) begin
      if (sb.size() == 0)
        check("unexpected_xfer", {24'd0, dat_s}, 0);
      else
        check("data", {24'd0, dat_s},
              {24'd0, sb.pop_front()});
    end
    upd();
  endtask

  task automatic load(int base, int n);
    for (int i = 0; i < n; i++) begin
      fifo.push_back(8'(base + i));
      sb.push_back(8'(base + i));
    end
    upd();
  endtask

  task automatic drain(int lim);
    int n = 0;
    while (sb.size() > 0 && n < lim) begin
      tick();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic wait_flush(int lim);
    int n = 0;
    while (flush_busy && n < lim) begin
      check("flush_mvalid", {31'd0, m_valid}, 0);
      tick();
      n++;
    end
    check("flush_exit", {31'd0, flush_busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rrst_n  = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    upd();
    @(negedge clk);
    tick();
    tick();
    rrst_n = 1'b1;
    #1;
    check("rst_rinc", {31'd0, rinc}, 0);
    check("rst_mvalid", {31'd0, m_valid}, 0);
    check("rst_busy", {31'd0, flush_busy}, 0);
    check("rst_cnt", {16'd0, pop_count}, 0);
    check("rst_mdata", {24'd0, m_data}, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_rinc", {31'd0, rinc}, 0);
      check("idle_mvalid", {31'd0, m_valid}, 0);
    end
    check("idle_cnt", {16'd0, pop_count}, 0);

    // streaming 0x01..0x10
    m_ready = 1'b1;
    load(8'h01, 16);
    #1;
    check("lat_rinc", {31'd0, rinc}, 1);
    check("lat_mvalid", {31'd0, m_valid}, 0);
    tick();
    check("lat_mvalid1", {31'd0, m_valid}, 1);
    check("lat_mdata1", {24'd0, m_data}, 8'h01);
    for (int i = 0; i < 16; i++) begin
      check("no_bubble", {31'd0, m_valid}, 1);
      tick();
    end
    check("stream_done", {31'd0, m_valid}, 0);
    check("stream_sb", sb.size(), 0);
    check("stream_cnt", {16'd0, pop_count}, 16);
    check("stream_cnt4", {28'd0, pc4}, 0);

    // backpressure
    m_ready = 1'b0;
    pops = 0;
    load(8'hA0, 6);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_mvalid", {31'd0, m_valid}, 1);
      check("bp_mdata", {24'd0, m_data}, 8'hA0);
    end
    check("bp_pops", pops, 2);
    check("bp_rinc", {31'd0, rinc}, 0);
    m_ready = 1'b1;
    drain(30);
    check("bp_cnt", {16'd0, pop_count}, 22);

    // flush from TWO with backpressure
    m_ready = 1'b0;
    pops = 0;
    load(8'h11, 5);
    tick();
    tick();
    check("fl_pops2", pops, 2);
    check("fl_mdata", {24'd0, m_data}, 8'h11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", {31'd0, flush_busy}, 1);
    check("fl_mvalid", {31'd0, m_valid}, 0);
    wait_flush(20);
    check("fl_fifo", fifo.size(), 0);
    check("fl_pops", pops, 5);
    check("fl_cnt", {16'd0, pop_count}, 22);
    sb.delete();

    // flush on a transfer edge
    m_ready = 1'b1;
    load(8'h30, 8);
    tick();
    tick();
    tick();
    check("fx_mvalid", {31'd0, m_valid}, 1);
    check("fx_mdata", {24'd0, m_data}, 8'h32);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fx_mvalid0", {31'd0, m_valid}, 0);
    check("fx_cnt", {16'd0, pop_count}, 25);
    wait_flush(20);
    check("fx_fifo", fifo.size(), 0);
    check("fx_cnt2", {16'd0, pop_count}, 25);
    check("fx_cnt4", {28'd0, pc4}, 9);
    sb.delete();

    // counter wrap at CNT_W=4
    rrst_n = 1'b0;
    tick();
    rrst_n = 1'b1;
    check("wr_cnt0", {16'd0, pop_count}, 0);
    load(8'h50, 17);
    drain(40);
    check("wr_cnt4", {28'd0, pc4}, 1);
    check("wr_cnt", {16'd0, pop_count}, 17);

    // reset while in TWO
    m_ready = 1'b0;
    load(8'h60, 4);
    tick();
    tick();
    check("rt_mvalid", {31'd0, m_valid}, 1);
    check("rt_mdata", {24'd0, m_data}, 8'h60);
    pops = 0;
    rrst_n = 1'b0;
    #1;
    check("rt_rinc", {31'd0, rinc}, 0);
    tick();
    check("rt_mvalid0", {31'd0, m_valid}, 0);
    check("rt_rinc2", {31'd0, rinc}, 0);
    tick();
    check("rt_pops", pops, 0);
    rrst_n = 1'b1;
    #1;
    sb = fifo;
    check("rt_cnt", {16'd0, pop_count}, 0);
    check("rt_left", sb.size(), 2);
    m_ready = 1'b1;
    drain(20);
    check("rt_cnt2", {16'd0, pop_count}, 2);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
